// File: rtl/uart_rx_frame.sv
// UART frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Single sample per bit, taken mid-bit relative to the detected start edge.
module uart_rx_frame #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] svld_q;
  logic                   s;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bitn_q, bitn_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       armed_q, armed_d;
  logic [7:0] dout_q, dout_d;
  logic       dv_q, dv_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Input synchronizer; svld_q marks when s reflects the real line rather than
  // the reset preset, so the preset ones cannot arm the receiver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      svld_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sin};
      svld_q <= {svld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      armed_q <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      armed_q <= armed_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: bit timing, sampling and frame result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    par_d   = par_q;
    armed_d = armed_q | (svld_q[SYNC_STAGES-1] & s);
    dout_d  = dout_q;
    dv_d    = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && !s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          bitn_d = '0;
          state_d = s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {s, shift_q[7:1]};
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (s) begin
            dout_d  = shift_q;
            dv_d    = 1'b1;
            perr_d  = ~(^shift_q ^ par_q);
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Busy covers the detect cycle in IDLE through the stop sample.
  always_comb begin
    busy = (state_q == START) || (state_q == DATA) || (state_q == PARITY) ||
           (state_q == STOP) || ((state_q == IDLE) && armed_q && !s);
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed scenarios plus random frames, checked
// against a frame-level expectation queue.
module tb_uart_rx_frame;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
  localparam int LAT  = 1 + SYNC + CPB / 2 + 10 * CPB;

  logic       clk;
  logic       rst;
  logic       sin;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
    logic [31:0] t;
  } exp_t;

  exp_t       expq[$];
  exp_t       mon_e;
  logic [7:0] last_data;
  int         cyc;
  int         busy_total;
  int         n_checks;
  int         n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      check_eq("reset_outputs", {20'd0, data_out, data_valid, parity_err, frame_err, busy}, 32'd0);
    end else begin
      if (busy) busy_total++;
      if (data_valid || frame_err) begin
        check_eq("dv_fe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
        if (expq.size() == 0) begin
          check_eq("unexpected_pulse", expq.size(), 32'd1);
        end else begin
          mon_e = expq.pop_front();
          check_eq("pulse_kind_ferr", {31'd0, frame_err}, {31'd0, mon_e.ferr});
          check_eq("data_out", {24'd0, data_out}, {24'd0, mon_e.data});
          if (data_valid) check_eq("parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
          check_eq("pulse_latency", cyc, mon_e.t);
        end
      end else begin
        check_eq("parity_err_idle", {31'd0, parity_err}, 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    sin = b;
    tick(CPB);
  endtask

  // Sends one frame and records what the receiver should report for it.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    exp_t e;
    e.ferr = ~stop;
    e.perr = (($countones(d) + int'(p)) % 2) == 0;
    e.data = stop ? d : last_data;
    e.t    = cyc + LAT;
    if (stop) last_data = d;
    expq.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stop);
  endtask

  function automatic logic odd_p(input logic [7:0] d);
    return ~(^d);
  endfunction

  task automatic drain;
    int k;
    k = 0;
    while (expq.size() != 0 && k < 400) begin
      tick(1);
      k++;
    end
    check_eq("drain", expq.size(), 32'd0);
  endtask

  initial begin
    int b0;
    logic [7:0] d;
    logic [7:0] a5;
    logic       badp;
    logic       fe;
    n_checks   = 0;
    n_errors   = 0;
    busy_total = 0;
    cyc        = 0;
    last_data  = 8'h00;
    sin        = 1'b1;
    rst        = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(10);

    // Single frame, busy duration from detect to stop sample.
    b0 = busy_total;
    send_frame(8'hE2, 1'b1, 1'b1);
    sin = 1'b1;
    tick(CPB);
    drain();
    check_eq("busy_cycles", busy_total - b0, 32'd169);

    // Back-to-back frames, no idle gap.
    send_frame(8'hFE, 1'b0, 1'b1);
    send_frame(8'h00, 1'b1, 1'b1);
    sin = 1'b1;
    tick(CPB);
    drain();

    // Bad parity.
    send_frame(8'h00, 1'b0, 1'b1);
    sin = 1'b1;
    tick(CPB);
    drain();

    // Stop bit low, line held low, then a good frame.
    send_frame(8'hFF, 1'b1, 1'b0);
    sin = 1'b0;
    tick(40);
    sin = 1'b1;
    tick(CPB);
    send_frame(8'h55, 1'b1, 1'b1);
    sin = 1'b1;
    tick(CPB);
    drain();

    // Short glitch in IDLE.
    sin = 1'b0;
    tick(4);
    sin = 1'b1;
    tick(30);
    check_eq("glitch_no_pulse", expq.size(), 32'd0);

    // Line held low through reset release.
    sin = 1'b0;
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    last_data = 8'h00;
    b0 = busy_total;
    tick(100);
    check_eq("held_low_busy", busy_total - b0, 32'd0);
    sin = 1'b1;
    tick(20);
    send_frame(8'h81, 1'b1, 1'b1);
    sin = 1'b1;
    tick(CPB);
    drain();

    // Reset in the middle of a frame.
    a5 = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(a5[i]);
    sin = a5[4];
    tick(CPB / 2);
    rst = 1'b1;
    tick(5);
    sin = 1'b1;
    tick(2);
    rst = 1'b0;
    last_data = 8'h00;
    tick(20);
    check_eq("after_abort_data", {24'd0, data_out}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1);
    sin = 1'b1;
    tick(CPB);
    drain();

    // Random frames: occasional bad parity or bad stop, random gaps.
    for (int n = 0; n < 25; n++) begin
      d    = 8'($urandom);
      badp = ($urandom % 5) == 0;
      fe   = ($urandom % 6) == 0;
      send_frame(d, odd_p(d) ^ badp, ~fe);
      if (fe) begin
        sin = 1'b0;
        tick(int'($urandom_range(1, 40)));
        sin = 1'b1;
        tick(CPB);
      end
      sin = 1'b1;
      tick(int'($urandom_range(0, 20)));
    end
    sin = 1'b1;
    tick(CPB);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
